player_ship_mover: RTL and testbench
====================================

Name: player_ship_mover

Overview:
Next-generation player-ship motion generator for the VGA game. It drives the ship's top-left X with per-frame acceleration and deceleration. It selects Y from a parametrised set of horizontal lanes, stepping one lane per button press. A collision input freezes the ship for a stun period. Inputs come from the keypad decoder; outputs feed the ship bitmap/drawer and the collision logic.

Parameters:
INITIAL_X, 280, reset X in pixels
LANE_COUNT, 2, number of Y lanes (>=1)
LANE_Y0, 406, Y of lane 0 (top lane), pixels
LANE_PITCH, 32, Y distance between adjacent lanes, pixels
FRAC_BITS, 6, fixed-point fraction bits (1/64 pixel)
ACCEL, 32, speed change per frame, fixed-point units
MAX_SPEED, 192, speed magnitude limit, fixed-point units per frame
LEFT_BOUNDARY, 5, minimum X, pixels
RIGHT_BOUNDARY, 570, maximum X, pixels
STUN_FRAMES, 30, frames frozen after a collision

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame
isGameMode  in  1  motion enabled when 1
RightMove  in  1  right key level
LeftMove  in  1  left key level
UpMove  in  1  up key level
DownMove  in  1  down key level
collision  in  1  one-cycle pulse: ship hit by enemy fire
topLeftX  out  11 signed  ship X, pixels
topLeftY  out  11 signed  ship Y, pixels
laneIdx  out  $clog2(LANE_COUNT) (min 1)  current lane
isStunned  out  1  1 while the ship is frozen

Behaviour:
- Interface: single clock clk; reset resetN is asynchronous, active-low.
- Reset values:
  - x_fp = INITIAL_X<<FRAC_BITS, so topLeftX = 280.
  - velocity = 0.
  - lane = LANE_COUNT-1, so topLeftY = 438 with defaults.
  - isStunned = 0; state = MOVE; stun counter = 0; collision latch cleared.
  - Reset mid-stun returns immediately to MOVE.
- Update timing: all state updates only on clk edges where startOfFrame=1 and isGameMode=1. Outputs reflect the update one cycle later, since they are registered from state.
- isGameMode=0: all state holds, and pending collision latch is still captured.
- Arithmetic:
  - x_fp and velocity are 32-bit signed.
  - topLeftX = x_fp >>> FRAC_BITS (floor).
  - topLeftY = LANE_Y0 + lane*LANE_PITCH.
- Direction: dir = +1 if Right&!Left; -1 if Left&!Right; 0 otherwise. Both keys pressed counts as no input.
- Velocity per frame in MOVE:
  - dir!=0: add dir*ACCEL, saturate to ±MAX_SPEED. Reversal passes through 0 naturally.
  - dir=0: move toward 0 by ACCEL, never overshooting 0.
- Position: x_next = x_fp + v_next.
  - If x_next < LEFT_BOUNDARY<<FRAC_BITS: clamp to that value and force velocity to 0.
  - If x_next > RIGHT_BOUNDARY<<FRAC_BITS: clamp likewise and force velocity to 0.
- Lanes: rising edge detection of UpMove/DownMove, sampled once per frame against the previous frame's sample.
  - Up edge: lane-1, saturate at 0.
  - Down edge: lane+1, saturate at LANE_COUNT-1.
  - Both edges in the same frame: no change.
  - Holding a key does not repeat.
- Collision:
  - The pulse is latched on any cycle.
  - At the next enabled frame in MOVE: go to STUNNED, set velocity to 0, load counter = STUN_FRAMES, clear latch. The position update is skipped in that frame.
- STUNNED:
  - Each enabled frame decrements the counter; X, Y, lane and velocity hold, and keys are ignored.
  - Edge history still updates, so a key held through the stun does not fire on exit.
  - When the counter reaches 0: go to MOVE. Motion resumes on the following frame.
  - Collisions while STUNNED are discarded (latch cleared, counter not reloaded).
- isStunned = (state==STUNNED).

Decomposition:
- Package player_pkg holds:
  - typedef enum {MOVE, STUNNED} ship_state_t;
  - FRAC_BITS default;
  - a saturating velocity-step function.
- One sub-module, lane_selector: edge detection, saturating lane counter, Y computation, and freeze input.
- The X/velocity/stun FSM stays in the top module.

Test Plan:
- Reset, then hold RightMove for 6 enabled frames -> velocity 32,64,…,192; topLeftX=290 (x_fp=18592); a 7th frame adds 192 (speed stays capped).
- From speed 192, release keys -> velocity 160,128,…,0 over 6 frames, then X constant; Right+Left together behaves identically.
- Hold RightMove until clamped -> topLeftX=570, velocity 0; keep holding -> stays 570. Mirror test on left -> topLeftX=5.
- After reset (lane 1, Y=438), hold UpMove 5 frames -> lane 0, Y=406 after first frame only. Second Up edge -> stays 406. Down edge -> 438. Up+Down same frame -> no change.
- collision pulse mid-frame while moving right at 192 -> next frame isStunned=1, X frozen for 30 frames despite Right held. Second collision during stun is ignored. Exit after 30th frame, then acceleration restarts from 32.
- Assert resetN low during stun, with isGameMode=0 frames interleaved -> immediate isStunned=0, X=280, Y=438. With isGameMode=0, no state changes on startOfFrame.

Source files
------------

// File: rtl/player_ship_mover_pkg.sv
// Shared types and helpers for the player-ship motion generator.
package player_pkg;

  typedef enum logic {MOVE = 1'b0, STUNNED = 1'b1} ship_state_t;

  localparam int FRAC_BITS_DEFAULT = 6;

  // One frame of velocity change: accelerate toward dir with a speed cap,
  // or bleed speed toward zero without crossing it when no direction is held.
  function automatic logic signed [31:0] stepVelocity(
    input logic signed [31:0] vel,
    input logic signed [1:0]  dir,
    input logic signed [31:0] accel,
    input logic signed [31:0] maxSpeed
  );
    logic signed [31:0] v;
    if (dir > 2'sd0) begin
      v = vel + accel;
      if (v > maxSpeed) v = maxSpeed;
    end else if (dir < 2'sd0) begin
      v = vel - accel;
      if (v < -maxSpeed) v = -maxSpeed;
    end else if (vel > accel) begin
      v = vel - accel;
    end else if (vel < -accel) begin
      v = vel + accel;
    end else begin
      v = '0;
    end
    return v;
  endfunction

  function automatic logic signed [10:0] laneToY(
    input int lane,
    input int laneY0,
    input int lanePitch
  );
    return 11'(laneY0 + lane * lanePitch);
  endfunction

endpackage

// File: rtl/player_ship_mover_lane_selector.sv
// Per-frame lane stepping from Up/Down key edges, with a freeze input.
module lane_selector
  import player_pkg::*;
#(
  parameter int LANE_COUNT = 2,
  parameter int LANE_Y0    = 406,
  parameter int LANE_PITCH = 32,
  localparam int LANE_W    = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                frameEn,
  input  logic                freeze,
  input  logic                UpMove,
  input  logic                DownMove,
  output logic [LANE_W-1:0]   laneIdx,
  output logic signed [10:0]  topLeftY
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANE_COUNT - 1);

  logic [LANE_W-1:0] lane;
  logic              upPrev;
  logic              downPrev;
  logic              upEdge;
  logic              downEdge;

  assign upEdge   = UpMove & ~upPrev;
  assign downEdge = DownMove & ~downPrev;

  // Key history advances every enabled frame, even when frozen, so a key
  // held through a freeze does not register as a new press afterwards.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lane     <= LAST_LANE;
      upPrev   <= 1'b0;
      downPrev <= 1'b0;
    end else if (frameEn) begin
      upPrev   <= UpMove;
      downPrev <= DownMove;
      if (!freeze) begin
        if (upEdge && !downEdge && lane != '0)
          lane <= lane - 1'b1;
        else if (downEdge && !upEdge && lane != LAST_LANE)
          lane <= lane + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      laneIdx  <= LAST_LANE;
      topLeftY <= laneToY(LANE_COUNT - 1, LANE_Y0, LANE_PITCH);
    end else begin
      laneIdx  <= lane;
      topLeftY <= laneToY(int'(lane), LANE_Y0, LANE_PITCH);
    end
  end

endmodule

// File: rtl/player_ship_mover.sv
// Player-ship motion: fixed-point X with acceleration, lane Y, collision stun.
module player_ship_mover
  import player_pkg::*;
#(
  parameter int INITIAL_X      = 280,
  parameter int LANE_COUNT     = 2,
  parameter int LANE_Y0        = 406,
  parameter int LANE_PITCH     = 32,
  parameter int FRAC_BITS      = FRAC_BITS_DEFAULT,
  parameter int ACCEL          = 32,
  parameter int MAX_SPEED      = 192,
  parameter int LEFT_BOUNDARY  = 5,
  parameter int RIGHT_BOUNDARY = 570,
  parameter int STUN_FRAMES    = 30,
  localparam int LANE_W        = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               isGameMode,
  input  logic               RightMove,
  input  logic               LeftMove,
  input  logic               UpMove,
  input  logic               DownMove,
  input  logic               collision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [LANE_W-1:0]  laneIdx,
  output logic               isStunned
);

  localparam int STUN_W = (STUN_FRAMES > 0) ? $clog2(STUN_FRAMES + 1) : 1;
  localparam logic signed [31:0] LEFT_FP  = 32'(LEFT_BOUNDARY << FRAC_BITS);
  localparam logic signed [31:0] RIGHT_FP = 32'(RIGHT_BOUNDARY << FRAC_BITS);
  localparam logic signed [31:0] INIT_FP  = 32'(INITIAL_X << FRAC_BITS);

  ship_state_t        state, stateNext;
  logic signed [31:0] xFp, xFpNext;
  logic signed [31:0] vel, velNext;
  logic [STUN_W-1:0]  stunCnt, stunCntNext;
  logic               collLatch;
  logic               frameEn;
  logic               stunnedNow;
  logic signed [1:0]  dir;
  logic signed [31:0] vStep;
  logic signed [31:0] xSum;

  assign frameEn = startOfFrame & isGameMode;
  assign dir     = (RightMove && !LeftMove) ? 2'sd1 :
                   (LeftMove && !RightMove) ? -2'sd1 : 2'sd0;
  assign vStep   = stepVelocity(vel, dir, ACCEL, MAX_SPEED);
  assign xSum    = xFp + vStep;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= MOVE;
      xFp       <= INIT_FP;
      vel       <= '0;
      stunCnt   <= '0;
      collLatch <= 1'b0;
    end else begin
      state   <= stateNext;
      xFp     <= xFpNext;
      vel     <= velNext;
      stunCnt <= stunCntNext;
      // Every enabled frame consumes the latch: it either starts a stun or is discarded.
      if (collision)
        collLatch <= 1'b1;
      else if (frameEn)
        collLatch <= 1'b0;
    end
  end

  always_comb begin
    stateNext   = state;
    xFpNext     = xFp;
    velNext     = vel;
    stunCntNext = stunCnt;
    if (frameEn) begin
      case (state)
        MOVE: begin
          if (collLatch) begin
            stateNext   = STUNNED;
            velNext     = '0;
            stunCntNext = STUN_W'(STUN_FRAMES);
          end else begin
            velNext = vStep;
            xFpNext = xSum;
            if (xSum < LEFT_FP) begin
              xFpNext = LEFT_FP;
              velNext = '0;
            end else if (xSum > RIGHT_FP) begin
              xFpNext = RIGHT_FP;
              velNext = '0;
            end
          end
        end
        STUNNED: begin
          if (stunCnt <= STUN_W'(1)) begin
            stunCntNext = '0;
            stateNext   = MOVE;
          end else begin
            stunCntNext = stunCnt - 1'b1;
          end
        end
        default: stateNext = MOVE;
      endcase
    end
  end

  always_comb begin
    stunnedNow = (state == STUNNED);
  end

  // Output stage: registered from state, one cycle behind each update.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      topLeftX  <= 11'(INITIAL_X);
      isStunned <= 1'b0;
    end else begin
      topLeftX  <= 11'(xFp >>> FRAC_BITS);
      isStunned <= stunnedNow;
    end
  end

  lane_selector #(
    .LANE_COUNT (LANE_COUNT),
    .LANE_Y0    (LANE_Y0),
    .LANE_PITCH (LANE_PITCH)
  ) laneSel (
    .clk      (clk),
    .resetN   (resetN),
    .frameEn  (frameEn),
    .freeze   (stunnedNow | collLatch),
    .UpMove   (UpMove),
    .DownMove (DownMove),
    .laneIdx  (laneIdx),
    .topLeftY (topLeftY)
  );

endmodule

// File: tb/tb_player_ship_mover.sv
// Scoreboard bench for player_ship_mover against a frame-level reference model.
module tb_player_ship_mover;

  localparam int INITIAL_X = 280;
  localparam int LANES     = 2;
  localparam int LANE_Y0   = 406;
  localparam int PITCH     = 32;
  localparam int FRAC      = 6;
  localparam int ACCEL     = 32;
  localparam int MAXSPD    = 192;
  localparam int LEFTB     = 5;
  localparam int RIGHTB    = 570;
  localparam int STUN      = 30;

  logic clk = 1'b0;
  logic resetN, startOfFrame, isGameMode;
  logic RightMove, LeftMove, UpMove, DownMove, collision;
  logic signed [10:0] topLeftX, topLeftY;
  logic [0:0] laneIdx;
  logic isStunned;

  always #5 clk = ~clk;

  player_ship_mover dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .isGameMode   (isGameMode),
    .RightMove    (RightMove),
    .LeftMove     (LeftMove),
    .UpMove       (UpMove),
    .DownMove     (DownMove),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .laneIdx      (laneIdx),
    .isStunned    (isStunned)
  );

  typedef struct {
    int x;
    int y;
    int lane;
    int stun;
  } exp_t;

  exp_t sbq[$];
  int nTests = 0;
  int nFail  = 0;

  // Reference model state: position in 1/64 pixel, speed, lane, stun frames left.
  int mX, mV, mLane, mLeft;
  bit mStun, mColl, mPrevUp, mPrevDn;

  function automatic void modelReset();
    mX = INITIAL_X * 64; mV = 0; mLane = LANES - 1; mLeft = 0;
    mStun = 0; mColl = 0; mPrevUp = 0; mPrevDn = 0;
  endfunction

  function automatic exp_t modelView();
    exp_t e;
    e.x = mX / 64;
    e.y = LANE_Y0 + mLane * PITCH;
    e.lane = mLane;
    e.stun = mStun ? 1 : 0;
    return e;
  endfunction

  function automatic void modelFrame(bit gm, bit r, bit l, bit u, bit d);
    int dir;
    bit upE, dnE;
    if (!gm) return;
    upE = u && !mPrevUp;
    dnE = d && !mPrevDn;
    mPrevUp = u;
    mPrevDn = d;
    if (mStun) begin
      mColl = 0;
      mLeft = mLeft - 1;
      if (mLeft == 0) mStun = 0;
      return;
    end
    if (mColl) begin
      mColl = 0; mStun = 1; mV = 0; mLeft = STUN;
      return;
    end
    dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    if (dir != 0) begin
      mV = mV + dir * ACCEL;
      if (mV > MAXSPD) mV = MAXSPD;
      if (mV < -MAXSPD) mV = -MAXSPD;
    end else if (mV > 0) begin
      mV = (mV > ACCEL) ? mV - ACCEL : 0;
    end else begin
      mV = (mV < -ACCEL) ? mV + ACCEL : 0;
    end
    mX = mX + mV;
    if (mX < LEFTB * 64) begin mX = LEFTB * 64; mV = 0; end
    if (mX > RIGHTB * 64) begin mX = RIGHTB * 64; mV = 0; end
    if (upE && !dnE && mLane > 0) mLane = mLane - 1;
    else if (dnE && !upE && mLane < LANES - 1) mLane = mLane + 1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    nTests++;
    if (act != req) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic frame(input bit gm, input bit r, input bit l, input bit u, input bit d);
    @(negedge clk);
    isGameMode = gm; RightMove = r; LeftMove = l; UpMove = u; DownMove = d;
    startOfFrame = 1'b1;
    modelFrame(gm, r, l, u, d);
    sbq.push_back(modelView());
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic collide();
    @(negedge clk);
    collision = 1'b1;
    mColl = 1;
    @(negedge clk);
    collision = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 1'b0;
    modelReset();
    #1;
    check("rst_x", int'(topLeftX), INITIAL_X);
    check("rst_y", int'(topLeftY), LANE_Y0 + (LANES - 1) * PITCH);
    check("rst_lane", int'(laneIdx), LANES - 1);
    check("rst_stun", int'(isStunned), 0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Monitor: outputs are valid two edges after a frame pulse is seen.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (startOfFrame === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        if (sbq.size() == 0) begin
          nTests++; nFail++;
          $display("FAIL sb_empty: got output with no expectation queued");
        end else begin
          e = sbq.pop_front();
          check("x", int'(topLeftX), e.x);
          check("y", int'(topLeftY), e.y);
          check("lane", int'(laneIdx), e.lane);
          check("stun", int'(isStunned), e.stun);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; isGameMode = 1'b0;
    RightMove = 1'b0; LeftMove = 1'b0; UpMove = 1'b0; DownMove = 1'b0; collision = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    doReset();
    frame(0, 1, 0, 0, 0);

    // Acceleration to the cap, then one more capped frame.
    for (int i = 0; i < 6; i++) frame(1, 1, 0, 0, 0);
    check("plan_x_290", int'(topLeftX), 290);
    frame(1, 1, 0, 0, 0);
    check("plan_x_293", int'(topLeftX), 293);

    // Coasting down, then both keys behaving as no input.
    for (int i = 0; i < 7; i++) frame(1, 0, 0, 0, 0);
    check("plan_x_301", int'(topLeftX), 301);
    for (int i = 0; i < 6; i++) frame(1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) frame(1, 1, 1, 0, 0);

    // Boundary clamps.
    for (int i = 0; i < 110; i++) frame(1, 1, 0, 0, 0);
    check("plan_right_clamp", int'(topLeftX), RIGHTB);
    for (int i = 0; i < 210; i++) frame(1, 0, 1, 0, 0);
    check("plan_left_clamp", int'(topLeftX), LEFTB);

    // Lanes.
    doReset();
    frame(1, 0, 0, 1, 0);
    check("plan_lane_up", int'(topLeftY), 406);
    for (int i = 0; i < 4; i++) frame(1, 0, 0, 1, 0);
    frame(1, 0, 0, 0, 0);
    frame(1, 0, 0, 1, 0);
    frame(1, 0, 0, 0, 0);
    frame(1, 0, 0, 0, 1);
    check("plan_lane_down", int'(topLeftY), 438);
    frame(1, 0, 0, 0, 0);
    frame(1, 0, 0, 1, 1);

    // Collision stun with a second collision ignored.
    for (int i = 0; i < 8; i++) frame(1, 1, 0, 0, 0);
    collide();
    frame(1, 1, 0, 0, 0);
    check("plan_stunned", int'(isStunned), 1);
    for (int i = 0; i < 5; i++) frame(1, 1, 0, 0, 0);
    collide();
    for (int i = 0; i < 25; i++) frame(1, 1, 0, 1, 0);
    check("plan_stun_last", int'(isStunned), 0);
    for (int i = 0; i < 4; i++) frame(1, 1, 0, 1, 0);

    // Reset mid-stun with disabled frames interleaved.
    collide();
    frame(1, 1, 0, 0, 0);
    frame(0, 1, 0, 0, 0);
    frame(1, 1, 0, 0, 0);
    frame(0, 0, 1, 1, 0);
    doReset();
    frame(0, 1, 0, 1, 0);
    frame(0, 0, 1, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) collide();
      frame($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    repeat (6) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
